// File: rtl/udma_i2s_pkg.sv
// Shared types for the uDMA I2S receive path: arbitration modes and source-ID width.
package udma_i2s_pkg;

  typedef enum logic [1:0] {
    SRC0_ONLY  = 2'b00,
    SRC1_ONLY  = 2'b01,
    INTERLEAVE = 2'b10,
    RR         = 2'b11
  } rx_arb_mode_e;

  localparam int unsigned SRC_ID_W = 1;

endpackage

// File: rtl/udma_i2s_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; synchronous clear beats push and pop.
module udma_i2s_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_c_o,
  output logic                  full_c_o,
  output logic                  empty_c_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic                  do_push, do_pop;

  assign full_c_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_c_o = (wptr_q == rptr_q);
  assign data_c_o  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i && !full_c_o && !clr_i;
  assign do_pop  = pop_i && !empty_c_o && !clr_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (do_pop)  rptr_d = rptr_q + PW'(1);
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: reads are only meaningful when not empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/udma_i2s_rx_arb.sv
// Merges the two I2S RX word streams onto the uDMA RX port with per-source buffering.
// Optional drop counters are built when UDMA_I2S_RX_DROP_CNT_EN is defined.
module udma_i2s_rx_arb
  import udma_i2s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
`ifdef UDMA_I2S_RX_DROP_CNT_EN
  , parameter int unsigned CNT_WIDTH = 16
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_en_i,
  input  logic [1:0]            cfg_mode_i,
  input  logic                  cfg_clr_i,
  input  logic [DATA_WIDTH-1:0] src0_data_i,
  input  logic                  src0_valid_i,
  input  logic [DATA_WIDTH-1:0] src1_data_i,
  input  logic                  src1_valid_i,
  output logic [DATA_WIDTH-1:0] data_rx_o,
  output logic                  data_rx_valid_o,
  input  logic                  data_rx_ready_i,
  output logic [SRC_ID_W-1:0]   data_rx_src_o,
  output logic [1:0]            overflow_o
`ifdef UDMA_I2S_RX_DROP_CNT_EN
  , output logic [CNT_WIDTH-1:0] drop_cnt0_o
  , output logic [CNT_WIDTH-1:0] drop_cnt1_o
`endif
);

  rx_arb_mode_e          mode;
  logic                  admit0, admit1, want0, want1;
  logic                  push0, push1, drop0, drop1;
  logic                  full0, full1, empty0, empty1;
  logic [DATA_WIDTH-1:0] fdata0, fdata1;
  logic                  sel_valid, sel_src, can_load, load;
  logic                  pop0, pop1;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [SRC_ID_W-1:0]   src_q, src_d;
  logic                  ptr_q, ptr_d;
  logic [1:0]            ovf_q, ovf_d;

  assign mode   = rx_arb_mode_e'(cfg_mode_i);
  assign admit0 = (mode == SRC0_ONLY) || cfg_mode_i[1];
  assign admit1 = (mode == SRC1_ONLY) || cfg_mode_i[1];
  assign want0  = src0_valid_i && cfg_en_i && admit0 && !cfg_clr_i;
  assign want1  = src1_valid_i && cfg_en_i && admit1 && !cfg_clr_i;
  assign push0  = want0 && !full0;
  assign push1  = want1 && !full1;
  assign drop0  = want0 && full0;
  assign drop1  = want1 && full1;

  udma_i2s_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (cfg_clr_i),
    .push_i    (push0),
    .data_i    (src0_data_i),
    .pop_i     (pop0),
    .data_c_o  (fdata0),
    .full_c_o  (full0),
    .empty_c_o (empty0)
  );

  udma_i2s_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (cfg_clr_i),
    .push_i    (push1),
    .data_i    (src1_data_i),
    .pop_i     (pop1),
    .data_c_o  (fdata1),
    .full_c_o  (full1),
    .empty_c_o (empty1)
  );

  // Source selection; ptr_q is the next expected (INTERLEAVE) or preferred (RR) source.
  always_comb begin
    sel_valid = 1'b0;
    sel_src   = 1'b0;
    case (mode)
      SRC0_ONLY: begin
        sel_valid = !empty0;
        sel_src   = 1'b0;
      end
      SRC1_ONLY: begin
        sel_valid = !empty1;
        sel_src   = 1'b1;
      end
      INTERLEAVE: begin
        if (cfg_en_i) begin
          sel_src   = ptr_q;
          sel_valid = ptr_q ? !empty1 : !empty0;
        end else begin
          // Disabled: pointer is parked at 0, so drain leftovers work-conserving.
          sel_src   = empty0;
          sel_valid = !(empty0 && empty1);
        end
      end
      default: begin
        sel_src   = (ptr_q ? !empty1 : !empty0) ? ptr_q : !ptr_q;
        sel_valid = !(empty0 && empty1);
      end
    endcase
  end

  assign can_load = !valid_q || data_rx_ready_i;
  assign load     = can_load && sel_valid && !cfg_clr_i;
  assign pop0     = load && !sel_src;
  assign pop1     = load && sel_src;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    ovf_d   = {drop1, drop0};
    if (can_load) begin
      valid_d = sel_valid;
      if (sel_valid) begin
        data_d = sel_src ? fdata1 : fdata0;
        src_d  = SRC_ID_W'(sel_src);
        ptr_d  = !sel_src;
      end
    end
    if (!cfg_en_i) ptr_d = 1'b0;
    if (cfg_clr_i) begin
      valid_d = 1'b0;
      ptr_d   = 1'b0;
      ovf_d   = 2'b00;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      src_q   <= '0;
      ptr_q   <= 1'b0;
      ovf_q   <= 2'b00;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_rx_o       = data_q;
  assign data_rx_valid_o = valid_q;
  assign data_rx_src_o   = src_q;
  assign overflow_o      = ovf_q;

`ifdef UDMA_I2S_RX_DROP_CNT_EN
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Saturating drop counters.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (drop0 && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_WIDTH'(1);
    if (drop1 && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_WIDTH'(1);
    if (cfg_clr_i) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign drop_cnt0_o = cnt0_q;
  assign drop_cnt1_o = cnt1_q;
`endif

endmodule

// File: tb/tb_udma_i2s_rx_arb.sv
// Directed bench for udma_i2s_rx_arb; drop-counter checks build with UDMA_I2S_RX_DROP_CNT_EN.
module tb_udma_i2s_rx_arb;
  import udma_i2s_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic        clr;
  logic [31:0] s0d, s1d;
  logic        s0v, s1v;
  logic [31:0] dout;
  logic        vout;
  logic        ready;
  logic [0:0]  sout;
  logic [1:0]  ovf;
`ifdef UDMA_I2S_RX_DROP_CNT_EN
  logic [3:0]  cnt0, cnt1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  udma_i2s_rx_arb #(
    .DATA_WIDTH(32),
    .FIFO_DEPTH(4)
`ifdef UDMA_I2S_RX_DROP_CNT_EN
    , .CNT_WIDTH(4)
`endif
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cfg_en_i        (en),
    .cfg_mode_i      (mode),
    .cfg_clr_i       (clr),
    .src0_data_i     (s0d),
    .src0_valid_i    (s0v),
    .src1_data_i     (s1d),
    .src1_valid_i    (s1v),
    .data_rx_o       (dout),
    .data_rx_valid_o (vout),
    .data_rx_ready_i (ready),
    .data_rx_src_o   (sout),
    .overflow_o      (ovf)
`ifdef UDMA_I2S_RX_DROP_CNT_EN
    , .drop_cnt0_o   (cnt0)
    , .drop_cnt1_o   (cnt1)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_and_clear;
    s0v = 1'b0; s1v = 1'b0; ready = 1'b0; en = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; mode = 2'b00; clr = 1'b0;
    s0v = 1'b0; s1v = 1'b0; s0d = '0; s1d = '0; ready = 1'b0;
    tick(); tick();
    total++; if (vout !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", vout); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", dout); end
    total++; if (sout !== 1'b0) begin bad++; $display("FAIL reset_src got=%0b exp=0", sout); end
    total++; if (ovf !== 2'b00) begin bad++; $display("FAIL reset_ovf got=%b exp=00", ovf); end
`ifdef UDMA_I2S_RX_DROP_CNT_EN
    total++; if (cnt0 !== 4'h0 || cnt1 !== 4'h0) begin bad++; $display("FAIL reset_cnt got=%h/%h exp=0/0", cnt0, cnt1); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_interleave;
    idle_and_clear();
    mode = INTERLEAVE; en = 1'b1; ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      s1v = (c == 0); s1d = 32'hB1;
      s0v = (c == 3); s0d = 32'hA0;
      if (c == 5) begin
        total++; if (vout !== 1'b1 || dout !== 32'hA0 || sout !== 1'b0) begin
          bad++; $display("FAIL il_first v/d/s got=%0b/%h/%0b exp=1/a0/0", vout, dout, sout); end
      end else if (c == 6) begin
        total++; if (vout !== 1'b1 || dout !== 32'hB1 || sout !== 1'b1) begin
          bad++; $display("FAIL il_second v/d/s got=%0b/%h/%0b exp=1/b1/1", vout, dout, sout); end
      end else begin
        total++; if (vout !== 1'b0) begin bad++; $display("FAIL il_idle c=%0d got=%0b exp=0", c, vout); end
      end
      tick();
    end
    s0v = 1'b0; s1v = 1'b0;
  endtask

  task automatic test_rr;
    logic        es;
    logic [31:0] ed;
    idle_and_clear();
    mode = RR; en = 1'b1; ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      s0v = (c < 4); s0d = 32'h100 + 32'(c);
      s1v = (c < 4); s1d = 32'h200 + 32'(c);
      if (c >= 2 && c <= 9) begin
        es = 1'((c - 2) % 2);
        ed = (es ? 32'h200 : 32'h100) + 32'((c - 2) / 2);
        total++; if (vout !== 1'b1 || dout !== ed || sout !== es) begin
          bad++; $display("FAIL rr_grant c=%0d v/d/s got=%0b/%h/%0b exp=1/%h/%0b", c, vout, dout, sout, ed, es); end
      end else begin
        total++; if (vout !== 1'b0) begin bad++; $display("FAIL rr_idle c=%0d got=%0b exp=0", c, vout); end
      end
      total++; if (ovf !== 2'b00) begin bad++; $display("FAIL rr_ovf c=%0d got=%b exp=00", c, ovf); end
      tick();
    end
    s0v = 1'b0; s1v = 1'b0;
  endtask

  task automatic test_overflow;
    idle_and_clear();
    mode = SRC0_ONLY; en = 1'b1; ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      s0v = (c <= 5); s0d = 32'(c + 1);
      total++; if (ovf !== ((c == 6) ? 2'b01 : 2'b00)) begin
        bad++; $display("FAIL ovf_pulse c=%0d got=%b exp=%b", c, ovf, (c == 6) ? 2'b01 : 2'b00); end
      if (c >= 2) begin
        total++; if (vout !== 1'b1 || dout !== 32'h1) begin
          bad++; $display("FAIL ovf_head c=%0d v/d got=%0b/%h exp=1/1", c, vout, dout); end
      end
`ifdef UDMA_I2S_RX_DROP_CNT_EN
      if (c == 7) begin
        total++; if (cnt0 !== 4'h1) begin bad++; $display("FAIL ovf_cnt0 got=%h exp=1", cnt0); end
      end
`endif
      tick();
    end
    s0v = 1'b0;
  endtask

  // Continues from test_overflow: head word 0x1 stalled, FIFO holds 0x2..0x5.
  task automatic test_hold;
    for (int i = 0; i < 10; i++) begin
      total++; if (vout !== 1'b1 || dout !== 32'h1 || sout !== 1'b0) begin
        bad++; $display("FAIL hold i=%0d v/d/s got=%0b/%h/%0b exp=1/1/0", i, vout, dout, sout); end
      tick();
    end
    ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      total++; if (vout !== 1'b1 || dout !== 32'(k)) begin
        bad++; $display("FAIL hold_drain k=%0d v/d got=%0b/%h exp=1/%h", k, vout, dout, 32'(k)); end
      tick();
    end
    total++; if (vout !== 1'b0) begin bad++; $display("FAIL hold_empty got=%0b exp=0", vout); end
  endtask

  task automatic test_clear;
    idle_and_clear();
    mode = RR; en = 1'b1; ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      s0v = 1'b1; s0d = 32'hC0 + 32'(c);
      s1v = 1'b1; s1d = 32'hD0 + 32'(c);
      tick();
    end
    total++; if (vout !== 1'b1 || dout !== 32'hC0) begin
      bad++; $display("FAIL clr_pre v/d got=%0b/%h exp=1/c0", vout, dout); end
    total++; if (ovf !== 2'b10) begin bad++; $display("FAIL clr_pre_ovf got=%b exp=10", ovf); end
`ifdef UDMA_I2S_RX_DROP_CNT_EN
    total++; if (cnt1 !== 4'h1) begin bad++; $display("FAIL clr_pre_cnt1 got=%h exp=1", cnt1); end
`endif
    clr = 1'b1; ready = 1'b1; s0d = 32'hEE; s1d = 32'hFF;
    tick();
    clr = 1'b0; s0v = 1'b0; s1v = 1'b0;
    total++; if (vout !== 1'b0) begin bad++; $display("FAIL clr_valid got=%0b exp=0", vout); end
    total++; if (ovf !== 2'b00) begin bad++; $display("FAIL clr_ovf got=%b exp=00", ovf); end
`ifdef UDMA_I2S_RX_DROP_CNT_EN
    total++; if (cnt0 !== 4'h0 || cnt1 !== 4'h0) begin bad++; $display("FAIL clr_cnt got=%h/%h exp=0/0", cnt0, cnt1); end
`endif
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (vout !== 1'b0) begin bad++; $display("FAIL clr_empty c=%0d got=%0b exp=0", c, vout); end
    end
  endtask

  task automatic test_gating;
    idle_and_clear();
    mode = SRC1_ONLY; en = 1'b1; ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      s0v = (c < 3); s0d = 32'h55;
      total++; if (vout !== 1'b0) begin bad++; $display("FAIL gate_mode c=%0d got=%0b exp=0", c, vout); end
      tick();
    end
    s0v = 1'b0;
    mode = RR; en = 1'b0;
    for (int c = 0; c < 6; c++) begin
      s0v = (c < 3); s1v = (c < 3);
      total++; if (vout !== 1'b0 || ovf !== 2'b00) begin
        bad++; $display("FAIL gate_en c=%0d v/ovf got=%0b/%b exp=0/00", c, vout, ovf); end
      tick();
    end
    s0v = 1'b0; s1v = 1'b0;
  endtask

`ifdef UDMA_I2S_RX_DROP_CNT_EN
  task automatic test_saturate;
    idle_and_clear();
    mode = SRC1_ONLY; en = 1'b1; ready = 1'b0;
    for (int c = 0; c < 26; c++) begin
      s1v = (c < 25); s1d = 32'(c);
      if (c == 15) begin
        total++; if (cnt1 !== 4'hA) begin bad++; $display("FAIL sat_mid got=%h exp=a", cnt1); end
      end
      if (c == 25) begin
        total++; if (cnt1 !== 4'hF) begin bad++; $display("FAIL sat_end got=%h exp=f", cnt1); end
      end
      tick();
    end
    s1v = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_interleave();
    test_rr();
    test_overflow();
    test_hold();
    test_clear();
    test_gating();
`ifdef UDMA_I2S_RX_DROP_CNT_EN
    test_saturate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
